// File: rtl/unique_dec_pkg.sv
// Shared types and helpers for the registered unique/priority select decoder.
// Error codes, mode encoding and the lowest-set-bit isolate used by the encoder.
package unique_dec_pkg;

    localparam int MAX_REQ_W = 64;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_NOMATCH = 2'd1,
        ERR_MULTI   = 2'd2
    } err_t;

    typedef enum logic {
        MODE_PRIORITY = 1'b0,
        MODE_UNIQUE   = 1'b1
    } mode_t;

    // Two's-complement trick: v & -v keeps only the lowest set bit.
    function automatic logic [MAX_REQ_W-1:0] onehot_lsb(
        input logic [MAX_REQ_W-1:0] v
    );
        return v & (~v + {{(MAX_REQ_W-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/pri_onehot_enc.sv
// Combinational lowest-bit-first one-hot/binary encoder with
// zero-match and multi-match flags.
module pri_onehot_enc
    import unique_dec_pkg::*;
#(
    parameter  int REQ_W = 4,
    localparam int IDX_W = $clog2(REQ_W)
) (
    input  logic [REQ_W-1:0] req,
    output logic [REQ_W-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             zero,
    output logic             multi
);

    assign grant = REQ_W'(onehot_lsb(MAX_REQ_W'(req)));
    assign zero  = ~|req;
    // Any request bit left after removing the winner means multi-hot.
    assign multi = |(req & ~grant);

    always_comb begin
        idx = '0;
        for (int i = 0; i < REQ_W; i++) begin
            if (grant[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/unique_sel_decoder_pipe.sv
// Registered select decoder: one-entry output stage behind a valid/ready
// handshake, with saturating no-match and multi-match counters.
module unique_sel_decoder_pipe
    import unique_dec_pkg::*;
#(
    parameter  int REQ_W = 4,
    parameter  int CNT_W = 8,
    localparam int IDX_W = $clog2(REQ_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             unique_mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [REQ_W-1:0] in_req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [REQ_W-1:0] out_grant,
    output logic [IDX_W-1:0] out_idx,
    output logic [1:0]       out_err,
    output logic [CNT_W-1:0] nomatch_cnt,
    output logic [CNT_W-1:0] multi_cnt,
    input  logic             cnt_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             valid_q, valid_d;
    logic [REQ_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    err_t             err_q, err_d;
    logic [CNT_W-1:0] nm_q, nm_d;
    logic [CNT_W-1:0] mu_q, mu_d;

    logic [REQ_W-1:0] enc_grant;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_zero;
    logic             enc_multi;
    logic             acc;
    mode_t            mode;

    pri_onehot_enc #(
        .REQ_W (REQ_W)
    ) u_enc (
        .req   (in_req),
        .grant (enc_grant),
        .idx   (enc_idx),
        .zero  (enc_zero),
        .multi (enc_multi)
    );

    assign mode     = mode_t'(unique_mode);
    assign in_ready = !valid_q || out_ready;
    assign acc      = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        err_d   = err_q;
        if (acc) begin
            valid_d = 1'b1;
            grant_d = enc_grant;
            idx_d   = enc_idx;
            unique case (1'b1)
                enc_zero:                           err_d = ERR_NOMATCH;
                enc_multi && mode == MODE_UNIQUE:   err_d = ERR_MULTI;
                default:                            err_d = ERR_NONE;
            endcase
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // A clear wins over an increment in the same cycle; that event is lost.
    always_comb begin
        nm_d = nm_q;
        mu_d = mu_q;
        if (cnt_clr) begin
            nm_d = '0;
            mu_d = '0;
        end else if (acc) begin
            if (enc_zero && nm_q != CNT_MAX) begin
                nm_d = nm_q + 1'b1;
            end
            if (enc_multi && mode == MODE_UNIQUE && mu_q != CNT_MAX) begin
                mu_d = mu_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            grant_q <= '0;
            idx_q   <= '0;
            err_q   <= ERR_NONE;
            nm_q    <= '0;
            mu_q    <= '0;
        end else begin
            valid_q <= valid_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            nm_q    <= nm_d;
            mu_q    <= mu_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_grant   = grant_q;
    assign out_idx     = idx_q;
    assign out_err     = err_q;
    assign nomatch_cnt = nm_q;
    assign multi_cnt   = mu_q;

endmodule

// File: tb/tb_unique_sel_decoder_pipe.sv
// Directed plus randomized bench for unique_sel_decoder_pipe (REQ_W=4,
// CNT_W=2) against a behavioural model built from popcount/lowest-bit rules.
module tb_unique_sel_decoder_pipe;

    localparam int REQ_W   = 4;
    localparam int CNT_W   = 2;
    localparam int IDX_W   = 2;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             unique_mode;
    logic             in_valid;
    logic             in_ready;
    logic [REQ_W-1:0] in_req;
    logic             out_valid;
    logic             out_ready;
    logic [REQ_W-1:0] out_grant;
    logic [IDX_W-1:0] out_idx;
    logic [1:0]       out_err;
    logic [CNT_W-1:0] nomatch_cnt;
    logic [CNT_W-1:0] multi_cnt;
    logic             cnt_clr;

    always #5 clk = ~clk;

    unique_sel_decoder_pipe #(
        .REQ_W (REQ_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .unique_mode (unique_mode),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_req      (in_req),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_grant   (out_grant),
        .out_idx     (out_idx),
        .out_err     (out_err),
        .nomatch_cnt (nomatch_cnt),
        .multi_cnt   (multi_cnt),
        .cnt_clr     (cnt_clr)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic       m_valid;
    logic [3:0] m_grant;
    int         m_idx;
    int         m_err;
    int         m_nm;
    int         m_mu;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_grant = '0;
        m_idx   = 0;
        m_err   = 0;
        m_nm    = 0;
        m_mu    = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out_valid"}, 8'(out_valid), 8'(m_valid));
        chk({tag, ".out_grant"}, 8'(out_grant), 8'(m_grant));
        chk({tag, ".out_idx"}, 8'(out_idx), 8'(m_idx));
        chk({tag, ".out_err"}, 8'(out_err), 8'(m_err));
        chk({tag, ".nomatch_cnt"}, 8'(nomatch_cnt), 8'(m_nm));
        chk({tag, ".multi_cnt"}, 8'(multi_cnt), 8'(m_mu));
    endtask

    // Called at a negedge: drive inputs, check in_ready, clock, then check.
    task automatic cycle(input string tag, input logic v,
                         input logic [3:0] req, input logic um,
                         input logic ordy, input logic clr);
        logic exp_rdy;
        logic acc;
        int   pc;
        int   low;
        in_valid    = v;
        in_req      = req;
        unique_mode = um;
        out_ready   = ordy;
        cnt_clr     = clr;
        #1;
        exp_rdy = !m_valid || ordy;
        chk({tag, ".in_ready"}, 8'(in_ready), 8'(exp_rdy));
        if (v) begin
            n_vec++;
            assert (!$isunknown(in_req)) else begin
                n_bad++;
                $error("FAIL %s.in_req_known observed=%b expected=known",
                       tag, in_req);
            end
        end
        @(posedge clk);
        acc = v && exp_rdy;
        pc  = $countones(req);
        low = -1;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) low = i;
        end
        if (clr) begin
            m_nm = 0;
            m_mu = 0;
        end else if (acc) begin
            if (pc == 0 && m_nm < CNT_SAT) m_nm++;
            if (pc >= 2 && um && m_mu < CNT_SAT) m_mu++;
        end
        if (acc) begin
            m_valid = 1'b1;
            m_grant = (pc == 0) ? 4'd0 : 4'(1 << low);
            m_idx   = (pc == 0) ? 0 : low;
            m_err   = (pc == 0) ? 1 : ((pc >= 2 && um) ? 2 : 0);
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        rst_n       = 1'b0;
        unique_mode = 1'b1;
        in_valid    = 1'b0;
        in_req      = '0;
        out_ready   = 1'b1;
        cnt_clr     = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        chk("reset.in_ready", 8'(in_ready), 8'd1);
        rst_n = 1'b1;
        @(negedge clk);

        cycle("onehot", 1'b1, 4'b0100, 1'b1, 1'b1, 1'b0);
        cycle("multi_u", 1'b1, 4'b1010, 1'b1, 1'b1, 1'b0);
        cycle("multi_p", 1'b1, 4'b1010, 1'b0, 1'b1, 1'b0);
        cycle("zero_u", 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0);
        cycle("zero_p", 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0);
        cycle("drain", 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);

        cycle("bp_load", 1'b1, 4'b1000, 1'b1, 1'b0, 1'b0);
        repeat (3) cycle("bp_hold", 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
        cycle("bp_xfer", 1'b1, 4'b0110, 1'b1, 1'b1, 1'b0);
        cycle("bp_next", 1'b1, 4'b0001, 1'b0, 1'b1, 1'b0);

        cycle("clr0", 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1);
        repeat (5) cycle("sat", 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0);
        cycle("clr_wins", 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1);
        repeat (4) cycle("msat", 1'b1, 4'b1111, 1'b1, 1'b1, 1'b0);

        cycle("mid_load", 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("midrst");
        chk("midrst.in_ready", 8'(in_ready), 8'd1);
        @(negedge clk);
        rst_n = 1'b1;
        cycle("post_rst", 1'b1, 4'b1100, 1'b1, 1'b1, 1'b0);

        for (int n = 0; n < 400; n++) begin
            cycle("rand",
                  1'($urandom_range(0, 3) != 0),
                  4'($urandom),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
